add_requester: RTL and testbench
================================

ADD_REQUESTER -- requirements
Module: add_requester

Interface
REQ-001 Parameter W, default 8, SHALL set operand and result width.
REQ-002 Parameter TIMEOUT, default 15, SHALL set the maximum number of cycles spent in WAIT before abort (range 1..255).
REQ-003 Parameter CAP_DLY, default 1, SHALL set cycles from observed valid to sampling y (range 0..3).
REQ-004 clk  input  1  SHALL be the clock; all state updates on rising edge.
REQ-005 rst_n  input  1  SHALL be the reset, asynchronous, active-low.
REQ-006 req_valid  input  1  SHALL indicate an upstream request is offered.
REQ-007 req_ready  output  1  SHALL indicate the block accepts a request this cycle.
REQ-008 req_a, req_b  input  W  SHALL carry the request operands.
REQ-009 start  output  1  SHALL be the one-cycle issue pulse to the adder unit.
REQ-010 a, b  output  W  SHALL carry operands to the adder unit.
REQ-011 y  input  W  SHALL carry the adder unit result.
REQ-012 valid  input  1  SHALL carry the adder unit completion indication.
REQ-013 rsp_valid  output  1  SHALL indicate a response is offered downstream.
REQ-014 rsp_ready  input  1  SHALL indicate downstream accepts the response.
REQ-015 rsp_sum  output  W  SHALL carry the captured result.
REQ-016 rsp_err  output  1  SHALL flag a timed-out transaction.
REQ-017 err_cnt  output  8  SHALL count timeouts since reset.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, CAPT, RESP; one transaction in flight at a time.
REQ-019 IDLE: req_ready=1; on req_valid&req_ready latch req_a/req_b into a/b, go ISSUE.
REQ-020 req_ready SHALL be 0 in every state other than IDLE.
REQ-021 ISSUE: start=1 for exactly this one cycle; clear timer; go WAIT.
REQ-022 a, b SHALL hold stable from ISSUE until the block next accepts a request.
REQ-023 WAIT: timer increments each cycle; on valid=1 go CAPT (CAP_DLY>0) or capture y into rsp_sum and go RESP (CAP_DLY=0).
REQ-024 WAIT: after TIMEOUT cycles without valid, rsp_sum<=0, rsp_err<=1, err_cnt increments, go RESP.
REQ-025 valid=1 in the final WAIT cycle SHALL take priority over timeout (no error).
REQ-026 CAPT: wait CAP_DLY cycles after the valid cycle, then rsp_sum<=y, rsp_err<=0, go RESP.
REQ-027 RESP: rsp_valid=1; rsp_sum, rsp_err stable until rsp_valid&rsp_ready, then go IDLE.
REQ-028 valid SHALL be ignored in IDLE, ISSUE, CAPT, RESP.
REQ-029 err_cnt SHALL saturate at 255, never wrap.
REQ-030 rsp_sum SHALL be y as presented, no width extension; overflow wrap is the adder unit's (mod 2^W).
REQ-031 With CAP_DLY=1 and a responder asserting valid one cycle after start, rsp_valid SHALL rise 4 cycles after request acceptance.

Reset
REQ-032 On rst_n=0, at any time including mid-transaction: state IDLE, start=0, a=b=0, rsp_valid=0, rsp_sum=0, rsp_err=0, err_cnt=0, timer=0.
REQ-033 req_ready SHALL be 0 while rst_n=0 and 1 from the first clock edge after release.
REQ-034 An in-flight transaction SHALL be dropped by reset; later valid pulses are ignored per REQ-028.

Verification
REQ-035 req a=3,b=4, conforming responder (valid 1 cycle after start, y 2 cycles after) -> start pulse at cycle 1, rsp_valid at cycle 4, rsp_sum=7, rsp_err=0.
REQ-036 req a=200,b=100 -> rsp_sum=44, rsp_err=0.
REQ-037 responder never asserts valid -> after 15 WAIT cycles rsp_valid=1, rsp_err=1, rsp_sum=0, err_cnt=1.
REQ-038 rsp_ready held 0 for 5 cycles in RESP with req_valid=1 -> rsp_sum/rsp_err stable, req_ready=0, no request accepted until handshake.
REQ-039 valid asserted exactly on 15th WAIT cycle -> rsp_err=0, err_cnt unchanged.
REQ-040 rst_n pulsed low during WAIT, then valid pulsed -> all outputs at reset values, no rsp_valid produced; 256 timeouts -> err_cnt=255.

Source files
------------

// File: rtl/add_requester.sv
// -----------------------------------------------------------------------------
// add_requester
//
// Takes one request at a time from an upstream valid/ready port and issues it
// to an external adder unit: a one-cycle start pulse, with the operands held
// on a/b. It waits for the unit's completion strobe, samples the result after
// a configurable capture delay, and offers it downstream on a valid/ready port.
// If the unit stays silent for TIMEOUT cycles, the block returns an error
// response instead (sum 0, rsp_err 1) and bumps a saturating error counter.
//
// Parameters
//   W        operand / result width
//   TIMEOUT  WAIT cycles allowed before abort (1..255)
//   CAP_DLY  cycles from the observed valid to sampling y (0..3)
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   upstream request handshake
//   req_a, req_b          request operands
//   start                 one-cycle issue pulse to the adder unit
//   a, b                  operands to the adder unit (held until next accept)
//   y, valid              adder unit result and completion strobe
//   rsp_valid/rsp_ready   downstream response handshake
//   rsp_sum, rsp_err      captured result, timeout flag
//   err_cnt               saturating count of timeouts since reset
// -----------------------------------------------------------------------------
module add_requester #(
  parameter int W       = 8,
  parameter int TIMEOUT = 15,
  parameter int CAP_DLY = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic         start,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  input  logic [W-1:0] y,
  input  logic         valid,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_sum,
  output logic         rsp_err,
  output logic [7:0]   err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPT,
    S_RESP
  } state_e;

  // Timer value on the last permitted WAIT cycle and on the last CAPT cycle.
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0] CAPT_LAST  = (CAP_DLY > 0) ? 8'(CAP_DLY - 1) : 8'd0;

  state_e         state_q, state_d;
  logic [7:0]     timer_q, timer_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   rsp_sum_q, rsp_sum_d;
  logic           rsp_err_q, rsp_err_d;
  logic [7:0]     err_cnt_q, err_cnt_d;
  // Goes high on the first edge after reset release, so req_ready stays low
  // for the whole reset period even though the state is already IDLE.
  logic           out_of_rst_q;
  logic           accept;

  assign accept = req_valid && req_ready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so that every register
  // samples the pre-edge value of every other register, whatever the
  // statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      out_of_rst_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_of_rst_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in a combinational block gets a default at the
  // top, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        // A completion on the final WAIT cycle wins over the timeout.
        if (valid)                       state_d = (CAP_DLY == 0) ? S_RESP : S_CAPT;
        else if (timer_q == TIMER_LAST)  state_d = S_RESP;
      end
      S_CAPT:  if (timer_q == CAPT_LAST) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready = (state_q == S_IDLE) && out_of_rst_q;
    start     = (state_q == S_ISSUE);
    rsp_valid = (state_q == S_RESP);
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state: operands, timer, response, error counter
  // ---------------------------------------------------------------------------
  always_comb begin
    timer_d   = timer_q;
    a_d       = a_q;
    b_d       = b_q;
    rsp_sum_d = rsp_sum_q;
    rsp_err_d = rsp_err_q;
    err_cnt_d = err_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d = req_a;
          b_d = req_b;
        end
      end
      S_ISSUE: timer_d = '0;
      S_WAIT: begin
        if (valid) begin
          // The timer is reused to count the capture delay in CAPT.
          timer_d = '0;
          if (CAP_DLY == 0) begin
            rsp_sum_d = y;
            rsp_err_d = 1'b0;
          end
        end else if (timer_q == TIMER_LAST) begin
          rsp_sum_d = '0;
          rsp_err_d = 1'b1;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_CAPT: begin
        if (timer_q == CAPT_LAST) begin
          rsp_sum_d = y;
          rsp_err_d = 1'b0;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rsp_sum_q <= '0;
      rsp_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      timer_q   <= timer_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rsp_sum_q <= rsp_sum_d;
      rsp_err_q <= rsp_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign a       = a_q;
  assign b       = b_q;
  assign rsp_sum = rsp_sum_q;
  assign rsp_err = rsp_err_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_add_requester.sv
// -----------------------------------------------------------------------------
// tb_add_requester
//
// Directed bench for add_requester (default parameters). A scripted adder
// responder raises valid a chosen number of cycles after start and presents
// the sum from two cycles after start. A transaction-level model predicts, at
// each acceptance, when start fires, when the response appears, and what it
// carries. A compare process checks every output against the model on every
// falling edge. Literal expectations in the directed sequence pin the model.
// -----------------------------------------------------------------------------
module tb_add_requester;

  localparam int         W       = 8;
  localparam int         TIMEOUT = 15;
  localparam int         CAP_DLY = 1;
  localparam logic [7:0] JUNK    = 8'hEE;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_a     = '0;
  logic [7:0] req_b     = '0;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] y         = JUNK;
  logic       valid     = 1'b0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_sum;
  logic       rsp_err;
  logic [7:0] err_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Responder script: valid delay after start (0 = never) and result value.
  int         cur_d    = 1;
  logic [7:0] cur_y    = '0;
  logic       spurious = 1'b0;
  int         resp_s   = -100;
  logic       armed    = 1'b0;

  add_requester #(.W(W), .TIMEOUT(TIMEOUT), .CAP_DLY(CAP_DLY)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .start     (start),
    .a         (a),
    .b         (b),
    .y         (y),
    .valid     (valid),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_err   (rsp_err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Adder responder: driven on the falling edge from the observed start.
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge clk);
      if (start) begin
        resp_s = cyc;
        armed  = 1'b1;
      end
      valid = (armed && cur_d != 0 && cyc == resp_s + cur_d) || spurious;
      y     = (armed && cyc >= resp_s + 2) ? cur_y : JUNK;
    end
  end

  // ---------------------------------------------------------------------------
  // Transaction-level model. On acceptance it schedules the whole transaction:
  // start one cycle later; the valid pulse counts only if it lands inside the
  // TIMEOUT-cycle window that follows start; the result is sampled CAP_DLY
  // cycles after valid and appears the cycle after that; otherwise the error
  // response appears right after the window closes.
  // ---------------------------------------------------------------------------
  typedef enum {M_IDLE, M_BUSY, M_RESP} mphase_e;

  mphase_e    m_phase    = M_IDLE;
  logic       m_en       = 1'b0;
  int         m_issue    = -1;
  int         m_resp     = -1;
  logic [7:0] m_a        = '0;
  logic [7:0] m_b        = '0;
  logic [7:0] m_sum      = '0;
  logic       m_err      = 1'b0;
  logic [7:0] m_pend_sum = '0;
  logic       m_pend_err = 1'b0;
  logic [7:0] m_cnt      = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= M_IDLE;
      m_en    <= 1'b0;
      m_issue <= -1;
      m_a     <= '0;
      m_b     <= '0;
      m_sum   <= '0;
      m_err   <= 1'b0;
      m_cnt   <= '0;
    end else begin
      m_en <= 1'b1;
      case (m_phase)
        M_IDLE: begin
          if (m_en && req_valid) begin
            m_a     <= req_a;
            m_b     <= req_b;
            m_issue <= cyc + 1;
            m_phase <= M_BUSY;
            if (cur_d >= 1 && cur_d <= TIMEOUT) begin
              m_resp     <= cyc + 2 + cur_d + CAP_DLY;
              m_pend_err <= 1'b0;
              // y carries the sum from two cycles after start onwards.
              m_pend_sum <= (cur_d + CAP_DLY >= 2) ? 8'(req_a + req_b) : JUNK;
            end else begin
              m_resp     <= cyc + 2 + TIMEOUT;
              m_pend_err <= 1'b1;
              m_pend_sum <= '0;
            end
          end
        end
        M_BUSY: begin
          if (cyc + 1 == m_resp) begin
            m_phase <= M_RESP;
            m_sum   <= m_pend_sum;
            m_err   <= m_pend_err;
            if (m_pend_err && m_cnt != 8'd255) m_cnt <= m_cnt + 8'd1;
          end
        end
        default: begin
          if (rsp_ready) m_phase <= M_IDLE;
        end
      endcase
    end
  end

  // Compare process: every output, every cycle.
  always @(negedge clk) begin
    check("req_ready", req_ready, (m_phase == M_IDLE) && m_en);
    check("start",     start,     (m_phase == M_BUSY) && (cyc == m_issue));
    check("a",         a,         m_a);
    check("b",         b,         m_b);
    check("rsp_valid", rsp_valid, m_phase == M_RESP);
    check("rsp_sum",   rsp_sum,   m_sum);
    check("rsp_err",   rsp_err,   m_err);
    check("err_cnt",   err_cnt,   m_cnt);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // One transaction. Entered and left on a falling edge with the block idle.
  // stall: cycles rsp_ready stays low in RESP (with spurious valid and, if
  // hold_req, a second request kept pending).
  // ---------------------------------------------------------------------------
  task automatic txn(input logic [7:0] op_a, input logic [7:0] op_b, input int d,
                     input int stall, input logic hold_req,
                     output logic [7:0] sum, output logic err,
                     output int lat, output int start_lat);
    int acc;
    cur_d     = d;
    cur_y     = 8'(op_a + op_b);
    req_a     = op_a;
    req_b     = op_b;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
    check("accept_wait", req_ready, 1);
    acc = cyc;
    @(negedge clk);
    if (hold_req) begin
      req_a = 8'h55;
      req_b = 8'h66;
    end else begin
      req_valid = 1'b0;
    end
    for (int i = 0; i < 60 && !rsp_valid; i++) @(negedge clk);
    check("rsp_wait", rsp_valid, 1);
    lat       = cyc - acc;
    start_lat = resp_s - acc;
    sum       = rsp_sum;
    err       = rsp_err;
    if (stall > 0) spurious = 1'b1;
    for (int i = 0; i < stall; i++) begin
      check("stall_req_ready", req_ready, 0);
      check("stall_rsp_valid", rsp_valid, 1);
      @(negedge clk);
    end
    spurious  = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] s;
    logic       e;
    int         lat;
    int         slat;
    int         acc;
    int         rises;

    // Reset and release.
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_err_cnt",   err_cnt,   0);
    #2 rst_n = 1'b1;
    #1 check("ready_before_edge", req_ready, 0);
    @(negedge clk);
    check("ready_after_edge", req_ready, 1);

    // 3 + 4, conforming responder.
    txn(8'd3, 8'd4, 1, 0, 1'b0, s, e, lat, slat);
    check("t1_sum", s, 7);
    check("t1_err", e, 0);
    check("t1_rsp_latency", lat, 4);
    check("t1_start_latency", slat, 1);

    // 200 + 100 wraps to 44.
    txn(8'd200, 8'd100, 1, 0, 1'b0, s, e, lat, slat);
    check("t2_sum", s, 44);
    check("t2_err", e, 0);

    // Silent responder: timeout after 15 WAIT cycles.
    txn(8'd5, 8'd6, 0, 0, 1'b0, s, e, lat, slat);
    check("t3_sum", s, 0);
    check("t3_err", e, 1);
    check("t3_rsp_latency", lat, 17);
    check("t3_err_cnt", err_cnt, 1);

    // Backpressure: 5 stalled cycles, pending request and stray valid.
    txn(8'd10, 8'd20, 1, 5, 1'b1, s, e, lat, slat);
    check("t4_sum", s, 30);
    check("t4_err", e, 0);
    check("t4_err_cnt", err_cnt, 1);

    // valid on the 15th WAIT cycle wins over the timeout.
    txn(8'd1, 8'd2, 15, 0, 1'b0, s, e, lat, slat);
    check("t5_sum", s, 3);
    check("t5_err", e, 0);
    check("t5_rsp_latency", lat, 18);
    check("t5_err_cnt", err_cnt, 1);

    // valid one cycle too late: timeout, and the late pulse lands in RESP.
    txn(8'd7, 8'd8, 16, 0, 1'b0, s, e, lat, slat);
    check("t6_sum", s, 0);
    check("t6_err", e, 1);
    check("t6_err_cnt", err_cnt, 2);

    // Reset during WAIT; the responder's valid arrives after release.
    cur_d     = 12;
    cur_y     = 8'd18;
    req_a     = 8'd9;
    req_b     = 8'd9;
    req_valid = 1'b1;
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
    check("r_accept_wait", req_ready, 1);
    acc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("r_a",         a,         0);
    check("r_b",         b,         0);
    check("r_start",     start,     0);
    check("r_req_ready", req_ready, 0);
    check("r_rsp_valid", rsp_valid, 0);
    check("r_rsp_sum",   rsp_sum,   0);
    check("r_rsp_err",   rsp_err,   0);
    check("r_err_cnt",   err_cnt,   0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    rises = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid) rises++;
    end
    check("r_valid_seen_after_release", (resp_s + cur_d > acc + 8) ? 1 : 0, 1);
    check("r_no_rsp_after_reset", rises, 0);
    check("r_ready_after_reset", req_ready, 1);

    // 256 timeouts: the counter saturates at 255.
    for (int i = 0; i < 256; i++) begin
      txn(8'(i), 8'd1, 0, 0, 1'b0, s, e, lat, slat);
      if (i == 254) check("sat_at_255", err_cnt, 255);
    end
    check("sat_after_256", err_cnt, 255);
    check("sat_last_err", e, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
